// File: rtl/draw_pkg.sv
// Shared types and constants for the frame drawing sequencer.
package draw_pkg;

  localparam int NUM_OBJ = 5;

  localparam int OBJ_PLAYER = 0;
  localparam int OBJ_E0     = 1;
  localparam int OBJ_E1     = 2;
  localparam int OBJ_E2     = 3;
  localparam int OBJ_E3     = 4;

  localparam logic [2:0] ERASE_COLOUR = 3'b000;

  typedef enum logic [2:0] {
    IDLE,
    E_START,
    E_WAIT,
    SNAP,
    D_START,
    D_WAIT,
    FIN
  } state_t;

endpackage

// File: rtl/draw_watchdog.sv
// Per-object watchdog: cleared on each object start, counts wait cycles,
// flags the terminal count TIMEOUT-1.
module draw_watchdog #(
  parameter int TIMEOUT = 2048
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic terminal
);

  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  logic [CNT_W-1:0] count;

  assign terminal = (count == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !terminal) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/draw_sequencer.sv
// Frame-level drawing controller: erase pass over last-drawn objects, coordinate
// snapshot, then draw pass over live objects, with tick queuing and a watchdog.
module draw_sequencer #(
  parameter int NUM_OBJ = 5,
  parameter int SEL_W   = 4,
  parameter int TIMEOUT = 2048
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               frame_tick,
  input  logic [NUM_OBJ-1:0] alive,
  input  logic               obj_done,
  output logic [SEL_W-1:0]   obj_sel,
  output logic               erase,
  output logic               obj_start,
  output logic               snapshot,
  output logic               plot,
  output logic               busy,
  output logic               frame_done,
  output logic               overrun,
  output logic               timeout_err
);

  import draw_pkg::*;

  state_t             state, state_nx;
  logic [SEL_W-1:0]   sel_nx, sel_inc;
  logic [NUM_OBJ-1:0] drawn_mask, mask_shift;
  logic               pending;
  logic               sel_live, sel_last, in_wait, wait_done, wd_term;

  assign mask_shift = drawn_mask >> obj_sel;
  assign sel_live   = mask_shift[0];
  assign sel_last   = (obj_sel == SEL_W'(NUM_OBJ - 1));
  assign sel_inc    = sel_last ? '0 : obj_sel + SEL_W'(1);
  assign in_wait    = (state == E_WAIT) || (state == D_WAIT);
  assign wait_done  = in_wait && (obj_done || wd_term);

  draw_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk      (clk),
    .reset    (reset),
    .clear    (obj_start),
    .enable   (in_wait),
    .terminal (wd_term)
  );

  always_comb begin
    state_nx   = state;
    sel_nx     = obj_sel;
    erase      = 1'b0;
    obj_start  = 1'b0;
    snapshot   = 1'b0;
    frame_done = 1'b0;
    busy       = (state != IDLE);
    case (state)
      IDLE: begin
        if (frame_tick || pending) begin
          state_nx = E_START;
          sel_nx   = '0;
        end
      end
      E_START, D_START: begin
        erase = (state == E_START);
        if (sel_live) begin
          obj_start = 1'b1;
          state_nx  = (state == E_START) ? E_WAIT : D_WAIT;
        end else begin
          // Dead object: one cycle per skipped index, no start strobe.
          sel_nx = sel_inc;
          if (sel_last) state_nx = (state == E_START) ? SNAP : FIN;
        end
      end
      E_WAIT, D_WAIT: begin
        erase = (state == E_WAIT);
        if (obj_done || wd_term) begin
          sel_nx = sel_inc;
          if (state == E_WAIT) state_nx = sel_last ? SNAP : E_START;
          else                 state_nx = sel_last ? FIN : D_START;
        end
      end
      SNAP: begin
        snapshot = 1'b1;
        state_nx = D_START;
        sel_nx   = '0;
      end
      FIN: begin
        frame_done = 1'b1;
        state_nx   = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      obj_sel     <= '0;
      plot        <= 1'b0;
      pending     <= 1'b0;
      overrun     <= 1'b0;
      timeout_err <= 1'b0;
      drawn_mask  <= '0;
    end else begin
      state   <= state_nx;
      obj_sel <= sel_nx;
      if (obj_start)      plot <= 1'b1;
      else if (wait_done) plot <= 1'b0;
      if (state == SNAP) drawn_mask <= alive;
      if (in_wait && wd_term && !obj_done) timeout_err <= 1'b1;
      // A tick arriving while a queued tick is being consumed stays queued.
      if (state == IDLE) begin
        pending <= pending && frame_tick;
      end else if (frame_tick) begin
        if (!pending) pending <= 1'b1;
        else          overrun <= 1'b1;
      end
    end
  end

endmodule
